// File: rtl/hdmi_video_pkg.sv
// Shared encodings and default SVGA timing for the HDMI video timing generator.
package hdmi_video_pkg;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    // {R,G,B} on/off flags, index 0 first: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 56;
    localparam int DEF_H_SYNC   = 120;
    localparam int DEF_H_BP     = 64;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 37;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 23;

endpackage

// File: rtl/hdmi_video_timing_gen_axis.sv
// One timing axis: counter with active/sync region decode and end-of-axis wrap strobe.
module hdmi_axis_counter #(
    parameter int ACTIVE = 800,
    parameter int FP     = 56,
    parameter int SYNC   = 120,
    parameter int BP     = 64,
    parameter bit POL    = 1'b1,
    parameter int W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         sync,
    output logic         wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);

    assign wrap   = inc && (cnt == LAST);
    assign active = (cnt < ACT_END);
    assign sync   = ((cnt >= SYNC_START) && (cnt < SYNC_END)) ? POL : ~POL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || wrap)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// Programmable video timing and test-pattern generator for the HDMI transmitter parallel bus.
module hdmi_video_timing_gen
    import hdmi_video_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int COLOR_BITS = 8,
    parameter int BAR_W      = 100,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                    clock50,
    input  logic                    reset_n,
    input  logic                    video_en,
    input  logic [1:0]              pattern_sel,
    input  logic [3*COLOR_BITS-1:0] solid_rgb,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    data_enable,
    output logic [3*COLOR_BITS-1:0] rgb_data,
    output logic                    frame_start,
    output logic                    running,
    output logic [7:0]              frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CB      = COLOR_BITS;
    localparam int BW      = $clog2(BAR_W + 1);

    state_e             state;
    pattern_e           pat_q;
    logic [3*CB-1:0]    solid_q;
    logic [7:0]         fc_q;

    logic [HW-1:0]      h_cnt;
    logic [VW-1:0]      v_cnt;
    logic               h_act, h_sync, h_wrap;
    logic               v_act, v_sync, v_wrap;
    logic               cnt_inc, cnt_clr, frame_end, start_frame;

    logic [BW-1:0]      bar_px;
    logic [2:0]         bar_idx;
    logic [2:0]         bar_flags;
    logic [HW-1:0]      h_cell;
    logic [VW-1:0]      v_cell;
    logic               chk_white;
    logic [3*CB-1:0]    pix;

    logic               s1_valid, s1_de, s1_hs, s1_vs, s1_fs;
    logic [3*CB-1:0]    s1_rgb;
    logic [7:0]         s1_fc;

    assign cnt_inc     = (state == ST_RUN);
    assign cnt_clr     = (state == ST_IDLE);
    assign frame_end   = h_wrap && v_wrap;
    assign start_frame = video_en && ((state == ST_IDLE) || frame_end);

    hdmi_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .W      (HW)
    ) u_h_axis (
        .clk    (clock50),
        .rst_n  (reset_n),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .cnt    (h_cnt),
        .active (h_act),
        .sync   (h_sync),
        .wrap   (h_wrap)
    );

    hdmi_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .W      (VW)
    ) u_v_axis (
        .clk    (clock50),
        .rst_n  (reset_n),
        .inc    (h_wrap),
        .clr    (cnt_clr),
        .cnt    (v_cnt),
        .active (v_act),
        .sync   (v_sync),
        .wrap   (v_wrap)
    );

    // Run/stop is only decided at the last pixel, so frames are never truncated
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            fc_q    <= '0;
            pat_q   <= PAT_BARS;
            solid_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (video_en) state <= ST_RUN;
                ST_RUN:  if (frame_end && !video_en) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (frame_end)
                fc_q <= fc_q + 8'd1;
            if (start_frame) begin
                pat_q   <= pattern_e'(pattern_sel);
                solid_q <= solid_rgb;
            end
        end
    end

    // Bar index tracks h_cnt / BAR_W incrementally; saturates on the black bar
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (cnt_clr || h_wrap) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (cnt_inc) begin
            if (bar_px == BW'(BAR_W - 1)) begin
                bar_px <= '0;
                if (bar_idx != 3'd7)
                    bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end

    assign bar_flags = BAR_TABLE[bar_idx];
    assign h_cell    = h_cnt >> CHECK_LOG2;
    assign v_cell    = v_cnt >> CHECK_LOG2;
    assign chk_white = (|(h_cell & HW'(1))) ^ (|(v_cell & VW'(1)));

    always_comb begin
        pix = '0;
        case (pat_q)
            PAT_BARS:     pix = {{CB{bar_flags[2]}}, {CB{bar_flags[1]}}, {CB{bar_flags[0]}}};
            PAT_GRADIENT: pix = {CB'(h_cnt), CB'(v_cnt), CB'(fc_q)};
            PAT_CHECKER:  pix = chk_white ? '1 : '0;
            PAT_SOLID:    pix = solid_q;
            default:      pix = '0;
        endcase
    end

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_de    <= 1'b0;
            s1_hs    <= ~HS_POL;
            s1_vs    <= ~VS_POL;
            s1_fs    <= 1'b0;
            s1_rgb   <= '0;
            s1_fc    <= '0;
        end else begin
            s1_valid <= (state == ST_RUN);
            s1_de    <= h_act && v_act;
            s1_hs    <= h_sync;
            s1_vs    <= v_sync;
            s1_fs    <= (state == ST_RUN) && (h_cnt == '0) && (v_cnt == '0);
            s1_rgb   <= (h_act && v_act) ? pix : '0;
            s1_fc    <= fc_q;
        end
    end

    // Idle values are forced while the stage-1 slot holds no running pixel
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            data_enable <= 1'b0;
            rgb_data    <= '0;
            frame_start <= 1'b0;
            running     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            hsync       <= s1_valid ? s1_hs : ~HS_POL;
            vsync       <= s1_valid ? s1_vs : ~VS_POL;
            data_enable <= s1_valid && s1_de;
            rgb_data    <= s1_valid ? s1_rgb : '0;
            frame_start <= s1_valid && s1_fs;
            running     <= ((state == ST_IDLE) && video_en) || (state == ST_RUN) || s1_valid;
            frame_cnt   <= s1_fc;
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Directed self-checking bench: small-timing instance for pixel-exact frames, plus default and active-low variants.
module tb_hdmi_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, en, en_d, en_n;
    logic [1:0]  pat;
    logic [23:0] solid;

    logic        hs, vs, de, fs, run;
    logic [23:0] rgb;
    logic [7:0]  fc;
    logic        d_hs, d_vs, d_de, d_fs, d_run;
    logic [23:0] d_rgb;
    logic [7:0]  d_fc;
    logic        n_hs, n_vs, n_de, n_fs, n_run;
    logic [23:0] n_rgb;
    logic [7:0]  n_fc;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // 24 x 10 totals, hsync x 18..20, vsync lines 7..8, 16 x 6 active
    hdmi_video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .BAR_W(2), .CHECK_LOG2(1)
    ) dut (
        .clock50(clk), .reset_n(reset_n), .video_en(en), .pattern_sel(pat), .solid_rgb(solid),
        .hsync(hs), .vsync(vs), .data_enable(de), .rgb_data(rgb),
        .frame_start(fs), .running(run), .frame_cnt(fc)
    );

    hdmi_video_timing_gen dut_def (
        .clock50(clk), .reset_n(reset_n), .video_en(en_d), .pattern_sel(pat), .solid_rgb(solid),
        .hsync(d_hs), .vsync(d_vs), .data_enable(d_de), .rgb_data(d_rgb),
        .frame_start(d_fs), .running(d_run), .frame_cnt(d_fc)
    );

    hdmi_video_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0)
    ) dut_neg (
        .clock50(clk), .reset_n(reset_n), .video_en(en_n), .pattern_sel(pat), .solid_rgb(solid),
        .hsync(n_hs), .vsync(n_vs), .data_enable(n_de), .rgb_data(n_rgb),
        .frame_start(n_fs), .running(n_run), .frame_cnt(n_fc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input logic [1:0] p, input int x, input int y,
                                            input logic [7:0] f, input logic [23:0] s);
        if (!(x < 16 && y < 6)) return 24'h0;
        case (p)
            2'd0:    return BARS[x / 2];
            2'd1:    return {8'(x), 8'(y), f};
            2'd2:    return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
            default: return s;
        endcase
    endfunction

    task automatic scan_frame(input logic [1:0] epat, input logic [23:0] esolid, input logic [7:0] efc,
                              input int chg_p, input logic [1:0] npat, input logic [23:0] nsolid,
                              input logic nen);
        int x, y;
        for (int p = 0; p < 240; p++) begin
            x = p % 24;
            y = p / 24;
            check($sformatf("f%0d pix x%0d y%0d", efc, x, y),
                  {run, fc, fs, de, hs, vs, rgb},
                  {1'b1, efc, (p == 0), (x < 16 && y < 6), (x >= 18 && x < 21), (y >= 7 && y < 9),
                   exp_rgb(epat, x, y, efc, esolid)});
            if (p == chg_p) begin
                pat   = npat;
                solid = nsolid;
                en    = nen;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs && n < 10);
        check(tag, n, 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, first, hcnt, dcnt;
        logic prev;

        reset_n = 1'b0; en = 1'b0; en_d = 1'b0; en_n = 1'b0; pat = 2'd0; solid = 24'h0;
        repeat (3) @(negedge clk);
        check("reset_small", {run, fc, fs, de, hs, vs, rgb}, 64'h0);
        check("reset_neg_hs", n_hs, 1);
        check("reset_def_hs", d_hs, 0);

        reset_n = 1'b1;
        @(negedge clk);
        en = 1'b1; en_d = 1'b1; en_n = 1'b1;
        wait_fs("start_latency");

        scan_frame(2'd0, 24'h0,      8'd0, 100, 2'd1, 24'h0,      1'b1);
        scan_frame(2'd1, 24'h0,      8'd1, 100, 2'd2, 24'h0,      1'b1);
        scan_frame(2'd2, 24'h0,      8'd2, 100, 2'd3, 24'h123456, 1'b1);
        scan_frame(2'd3, 24'h123456, 8'd3, 120, 2'd3, 24'hABCDEF, 1'b0);

        check("drained_fc", fc, 4);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("idle c%0d", i), {run, fs, hs, vs, de, rgb}, 64'h0);
            @(negedge clk);
        end
        en = 1'b1;
        wait_fs("restart_latency");
        check("restart_pix", {de, rgb, fc}, {1'b1, 24'hABCDEF, 8'd4});

        // Default SVGA line timing
        k = 0; prev = 1'b1;
        while (!(d_de && !prev) && k < 2100) begin
            prev = d_de;
            @(negedge clk);
            k++;
        end
        check("def_de_rise_found", (k < 2100), 1);
        first = -1; hcnt = 0; dcnt = 0;
        for (int p = 0; p < 1040; p++) begin
            if (d_hs && first < 0) first = p;
            hcnt += int'(d_hs);
            dcnt += int'(d_de);
            @(negedge clk);
        end
        check("def_hs_offset", first, 856);
        check("def_hs_width", hcnt, 120);
        check("def_de_width", dcnt, 800);
        check("def_next_line_de", d_de, 1);

        // Active-low hsync, 10-pixel lines
        k = 0; prev = 1'b1;
        while (!(n_de && !prev) && k < 200) begin
            prev = n_de;
            @(negedge clk);
            k++;
        end
        check("neg_de_rise_found", (k < 200), 1);
        first = -1; hcnt = 0; dcnt = 0;
        for (int p = 0; p < 18; p++) begin
            if (!n_hs && first < 0) first = p;
            hcnt += int'(!n_hs);
            dcnt += int'(n_de);
            @(negedge clk);
        end
        check("neg_hs_offset", first, 12);
        check("neg_hs_low_width", hcnt, 3);
        check("neg_de_width", dcnt, 10);

        // Asynchronous reset mid-line
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_small", {run, fc, fs, de, hs, vs, rgb}, 64'h0);
        check("async_reset_neg_hs", n_hs, 1);
        check("async_reset_def", {d_run, d_de, d_hs, d_vs}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
